// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: sequencer state encoding and reset-cause codes.
package reset_seq_pkg;
  typedef enum logic [1:0] {ST_ASSERT, ST_RELEASE, ST_RUN} state_t;
  localparam logic [1:0] CAUSE_WDOG = 2'b00;
  localparam logic [1:0] CAUSE_POR  = 2'b01;
  localparam logic [1:0] CAUSE_EXT  = 2'b10;
  localparam logic [1:0] CAUSE_SW   = 2'b11;
endpackage

// File: rtl/reset_seq_if.sv
// reset_seq_if: request inputs and staged reset outputs of reset_seq.
// RESET_SEQ_WDOG_EN adds the wdog_kick request.
interface reset_seq_if #(parameter int NUM_DOM = 4);
  logic ext_rst_req, sw_rst_req, test_mode;
  logic [NUM_DOM-1:0] rst_out_n;
  logic seq_busy, seq_done;
  logic [1:0] rst_cause;
`ifdef RESET_SEQ_WDOG_EN
  logic wdog_kick;
  modport master (output ext_rst_req, sw_rst_req, test_mode, wdog_kick,
                  input rst_out_n, seq_busy, seq_done, rst_cause);
  modport slave (input ext_rst_req, sw_rst_req, test_mode, wdog_kick,
                 output rst_out_n, seq_busy, seq_done, rst_cause);
`else
  modport master (output ext_rst_req, sw_rst_req, test_mode,
                  input rst_out_n, seq_busy, seq_done, rst_cause);
  modport slave (input ext_rst_req, sw_rst_req, test_mode,
                 output rst_out_n, seq_busy, seq_done, rst_cause);
`endif
endinterface

// File: rtl/reset_seq_filter.sv
// rst_req_filter: 2-FF synchroniser plus consecutive-high counter for ext_rst_req.
module rst_req_filter #(
  parameter int FILT_CYC = 8
) (
  input  logic clk,
  input  logic rst_async,
  input  logic req,
  output logic ext_hit
);
  localparam int FW = $clog2(FILT_CYC + 1);
  logic s1_q, s2_q;
  logic [FW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = !s2_q ? '0 : (cnt_q == FW'(FILT_CYC)) ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge clk or posedge rst_async)
    if (rst_async) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= req;
      s2_q  <= s1_q;
      cnt_q <= cnt_d;
    end
  assign ext_hit = cnt_q == FW'(FILT_CYC);
endmodule

// File: rtl/reset_seq.sv
// reset_seq: staged per-domain reset release with ext/sw reset requests and cause tracking.
// RESET_SEQ_WDOG_EN adds a watchdog that restarts the sequence when not kicked in RUN.
module reset_seq import reset_seq_pkg::*; #(
  parameter int NUM_DOM   = 4,
  parameter int STAGE_CYC = 16,
  parameter int FILT_CYC  = 8
`ifdef RESET_SEQ_WDOG_EN
  , parameter int WDOG_CYC = 1024
`endif
) (
  input logic        clk,
  input logic        rst_async,
  reset_seq_if.slave bus
);
  localparam int CW = $clog2(STAGE_CYC);
  localparam int IW = $clog2(NUM_DOM + 1);
  localparam logic [NUM_DOM-1:0] ONE = NUM_DOM'(1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NUM_DOM-1:0] rout_q, rout_d;
  logic [1:0] cause_q, cause_d;
  logic done_q, done_d;
  logic ext_hit, wdog_fire, restart, last;
  rst_req_filter #(.FILT_CYC(FILT_CYC)) u_filt (
    .clk(clk), .rst_async(rst_async), .req(bus.ext_rst_req), .ext_hit(ext_hit)
  );
`ifdef RESET_SEQ_WDOG_EN
  localparam int WW = $clog2(WDOG_CYC);
  logic [WW-1:0] wcnt_q, wcnt_d;
  assign wdog_fire = state_q == ST_RUN && wcnt_q == WW'(WDOG_CYC - 1) && !bus.wdog_kick;
  always_comb wcnt_d = (state_q != ST_RUN || bus.wdog_kick || wdog_fire) ? '0 : wcnt_q + 1'b1;
  always_ff @(posedge clk or posedge rst_async)
    if (rst_async) wcnt_q <= '0;
    else wcnt_q <= wcnt_d;
`else
  assign wdog_fire = 1'b0;
`endif
  assign restart = ext_hit || wdog_fire || (bus.sw_rst_req && state_q == ST_RUN);
  assign last = idx_q == IW'(NUM_DOM - 1);
  // ASSERT holds idx=0, so the end of the initial hold releases domain 0 like any later stage
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    rout_d  = rout_q;
    cause_d = cause_q;
    done_d  = 1'b0;
    if (restart) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
      rout_d  = '0;
      cause_d = ext_hit ? CAUSE_EXT : wdog_fire ? CAUSE_WDOG : CAUSE_SW;
    end else if (state_q == ST_RUN) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(STAGE_CYC - 1)) begin
      cnt_d   = '0;
      rout_d  = rout_q | (ONE << idx_q);
      idx_d   = idx_q + 1'b1;
      state_d = last ? ST_RUN : ST_RELEASE;
      done_d  = last;
    end
  end
  always_ff @(posedge clk or posedge rst_async)
    if (rst_async) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rout_q  <= '0;
      cause_q <= CAUSE_POR;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rout_q  <= rout_d;
      cause_q <= cause_d;
      done_q  <= done_d;
    end
  assign bus.rst_out_n = bus.test_mode ? {NUM_DOM{~rst_async}} : rout_q;
  assign bus.seq_busy  = state_q != ST_RUN;
  assign bus.seq_done  = done_q;
  assign bus.rst_cause = cause_q;
endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: scoreboard bench; a time-since-restart model predicts every cycle's outputs.
module tb_reset_seq;
  localparam int N = 4;
  localparam int S = 16;
  localparam int F = 8;
  localparam int W = 1024;
`ifdef RESET_SEQ_WDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  logic clk, rst_async;
  int n_tests = 0, n_fail = 0;
  logic [N+3:0] exp_q[$];
  int t, run, w;
  bit d1, d2;
  logic [1:0] cause;
  reset_seq_if #(.NUM_DOM(N)) bus ();
`ifdef RESET_SEQ_WDOG_EN
  reset_seq #(.NUM_DOM(N), .STAGE_CYC(S), .FILT_CYC(F), .WDOG_CYC(W)) dut (
    .clk(clk), .rst_async(rst_async), .bus(bus));
`else
  reset_seq #(.NUM_DOM(N), .STAGE_CYC(S), .FILT_CYC(F)) dut (
    .clk(clk), .rst_async(rst_async), .bus(bus));
`endif
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s act=%0d exp=%0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    t = 0; run = 0; w = 0; d1 = 0; d2 = 0; cause = 2'b01;
  endtask
  // t counts edges since the sequence last restarted; domain k is free once t >= (k+1)*S
  task automatic model_edge(input bit e, input bit s, input bit k);
    bit hit, running, fire;
    hit = run >= F;
    running = t >= N * S;
    fire = WD && running && w == W - 1 && !k;
    if (hit) begin t = 0; cause = 2'b10; end
    else if (fire) begin t = 0; cause = 2'b00; end
    else if (s && running) begin t = 0; cause = 2'b11; end
    else if (t <= N * S) t++;
    w = (running && !k && !fire) ? w + 1 : 0;
    run = d2 ? (run < F ? run + 1 : F) : 0;
    d2 = d1;
    d1 = e;
  endtask
  function automatic logic [N+3:0] model_out();
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = t >= (k + 1) * S;
    return {r, t < N * S, t == N * S, cause};
  endfunction
  // called at a falling edge; returns at the next falling edge
  task automatic step(input bit e, input bit s, input bit k);
    bus.ext_rst_req = e;
    bus.sw_rst_req = s;
`ifdef RESET_SEQ_WDOG_EN
    bus.wdog_kick = k;
`endif
    model_edge(e, s, k);
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask
  initial begin : mon
    logic [N+3:0] ex, ac;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        ex = exp_q.pop_front();
        ac = {bus.rst_out_n, bus.seq_busy, bus.seq_done, bus.rst_cause};
        n_tests++;
        if (ac !== ex) begin
          n_fail++;
          $display("FAIL seq_out act(rst_n,busy,done,cause)=%b exp=%b at %0t", ac, ex, $time);
        end
      end
    end
  end
  initial begin
    bit e;
    rst_async = 1'b1;
    bus.test_mode = 1'b0;
    bus.ext_rst_req = 1'b0;
    bus.sw_rst_req = 1'b0;
`ifdef RESET_SEQ_WDOG_EN
    bus.wdog_kick = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("por_rst_n", int'(bus.rst_out_n), 0);
    chk("por_busy", int'(bus.seq_busy), 1);
    chk("por_done", int'(bus.seq_done), 0);
    chk("por_cause", int'(bus.rst_cause), 1);
    rst_async = 1'b0;
    model_reset();
    repeat (70) step(0, 0, 0);
    repeat (5) step(1, 0, 0);
    repeat (20) step(0, 0, 0);
    repeat (40) step(1, 0, 0);
    repeat (70) step(0, 0, 0);
    step(0, 1, 0);
    repeat (30) step(0, 0, 0);
    step(0, 1, 0);
    repeat (40) step(0, 0, 0);
    step(0, 1, 0);
    repeat (40) step(0, 0, 0);
    rst_async = 1'b1;
    #1;
    chk("abort_rst_n", int'(bus.rst_out_n), 0);
    chk("abort_cause", int'(bus.rst_cause), 1);
    chk("abort_busy", int'(bus.seq_busy), 1);
    model_reset();
    @(negedge clk);
    rst_async = 1'b0;
    repeat (70) step(0, 0, 0);
    repeat (10) step(1, 0, 0);
    step(1, 1, 0);
    repeat (5) step(1, 0, 0);
    repeat (70) step(0, 0, 0);
`ifdef RESET_SEQ_WDOG_EN
    repeat (1100) step(0, 0, 0);
    repeat (70) step(0, 0, 0);
    repeat (3) begin
      repeat (999) step(0, 0, 0);
      step(0, 0, 1);
    end
`endif
    e = 1'b0;
    repeat (1500) begin
      if ($urandom_range(0, 15) == 0) e = ~e;
      step(e, $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
    end
    repeat (80) step(0, 0, 0);
    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    @(negedge clk);
    bus.test_mode = 1'b1;
    rst_async = 1'b1;
    #1;
    chk("tm_assert", int'(bus.rst_out_n), 0);
    rst_async = 1'b0;
    #1;
    chk("tm_release", int'(bus.rst_out_n), 15);
    chk("tm_busy", int'(bus.seq_busy), 1);
    repeat (2) @(negedge clk);
    chk("tm_hold", int'(bus.rst_out_n), 15);
    rst_async = 1'b1;
    #1;
    chk("tm_reassert", int'(bus.rst_out_n), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
